ahb_err_inject_sched: RTL and testbench

Scheduler and response sequencer for AHB error injection in the testbench fabric. It sits between an AHB slave's HREADYOUT/HRESP and the interconnect. It watches address phases and picks which transfers to a programmable address window receive an ERROR response, using an every-Nth period and a total injection budget. For each picked transfer it drives the two-cycle AHB ERROR sequence and exposes injection status to the bench.

---
 rtl/ahb_err_inject_sched.sv | 149 ++++++++++++++
 tb/tb_ahb_err_inject_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_err_inject_sched.sv
// ahb_err_inject_sched
// Picks transfers to a programmable address window for an AHB ERROR response
// and sequences the two-cycle ERROR on HREADYOUT_M/HRESP_M in place of the
// real slave response. Selection follows an every-Nth period and an optional
// total injection budget.

module ahb_err_inject_sched #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cfg_enable,
  input  logic [ADDR_WIDTH-1:0] cfg_addr_lo,
  input  logic [ADDR_WIDTH-1:0] cfg_addr_hi,
  input  logic [CNT_WIDTH-1:0]  cfg_period,
  input  logic [CNT_WIDTH-1:0]  cfg_budget,
  input  logic                  HSEL,
  input  logic                  HREADY,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HREADYOUT,
  input  logic                  HRESP,
  output logic                  HREADYOUT_M,
  output logic                  HRESP_M,
  output logic                  inject,
  output logic [CNT_WIDTH-1:0]  inject_count,
  output logic                  done
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + CNT_ONE;
  endfunction

  // Terminal count of the period counter; a period of 0 behaves as 1.
  function automatic logic [CNT_WIDTH-1:0] period_last(input logic [CNT_WIDTH-1:0] p);
    period_last = (p == '0) ? '0 : p - CNT_ONE;
  endfunction

  state_t                 state_p1;
  state_t                 state_nxt;
  logic [CNT_WIDTH-1:0]   period_cnt;

  logic                   vld_p0;
  logic                   in_win_p0;
  logic                   qual_p0;
  logic                   wrap_p0;
  logic                   select_p0;

  // Address phase (p0): HWRITE and HTRANS[0] do not influence selection.
  logic                   unused_in;
  assign unused_in = HWRITE ^ HTRANS[0];

  // ERR1 holds the bus HREADY low, so no address phase can be accepted there;
  // gating on the state keeps a misbehaving HREADY from re-triggering.
  assign vld_p0    = HSEL & HREADY & HTRANS[1] & (state_p1 != ST_ERR1);
  // An empty or inverted window (lo >= hi) can never satisfy both compares.
  assign in_win_p0 = (HADDR >= cfg_addr_lo) && (HADDR < cfg_addr_hi);
  assign qual_p0   = vld_p0 & in_win_p0 & cfg_enable;
  // >= rather than == so a live reduction of cfg_period below the current
  // count wraps at the next qualifying transfer instead of running to overflow.
  assign wrap_p0   = (period_cnt >= period_last(cfg_period));
  assign select_p0 = qual_p0 & wrap_p0 & ~done;

  assign done = (cfg_budget != '0) && (inject_count == cfg_budget);

  // Period counter: advances on every qualifying transfer, held at 0 while disabled.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      period_cnt <= '0;
    end else if (!cfg_enable) begin
      period_cnt <= '0;
    end else if (qual_p0) begin
      period_cnt <= wrap_p0 ? '0 : period_cnt + CNT_ONE;
    end
  end

  // Injection counter: one count per entry into ERR1.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      inject_count <= '0;
    end else if (select_p0) begin
      inject_count <= sat_inc(inject_count);
    end
  end

  // Data phase (p1): response sequencer state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_p1 <= ST_IDLE;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // Next-state logic: ERR1 drains the real slave's data phase, ERR2 is one cycle.
  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      ST_IDLE: begin
        if (select_p0) state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        if (HREADYOUT) state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        state_nxt = select_p0 ? ST_ERR1 : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode: pass-through in IDLE, forced ERROR response otherwise.
  always_comb begin
    HREADYOUT_M = HREADYOUT;
    HRESP_M     = HRESP;
    inject      = 1'b0;
    case (state_p1)
      ST_ERR1: begin
        HREADYOUT_M = 1'b0;
        HRESP_M     = 1'b1;
        inject      = 1'b1;
      end
      ST_ERR2: begin
        HREADYOUT_M = 1'b1;
        HRESP_M     = 1'b1;
        inject      = 1'b1;
      end
      default: begin
        HREADYOUT_M = HREADYOUT;
        HRESP_M     = HRESP;
        inject      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_err_inject_sched.sv
// Testbench for ahb_err_inject_sched: drives AHB transfers, queues the
// expected data-phase response per transfer and compares it when the data
// phase completes on the bus.

module tb_ahb_err_inject_sched;

  localparam int AW = 32;
  localparam int CW = 16;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          cfg_enable;
  logic [AW-1:0] cfg_addr_lo;
  logic [AW-1:0] cfg_addr_hi;
  logic [CW-1:0] cfg_period;
  logic [CW-1:0] cfg_budget;
  logic          HSEL;
  logic          HREADY;
  logic          HWRITE;
  logic [1:0]    HTRANS;
  logic [AW-1:0] HADDR;
  logic          HREADYOUT;
  logic          HRESP;
  logic          HREADYOUT_M;
  logic          HRESP_M;
  logic          inject;
  logic [CW-1:0] inject_count;
  logic          done;

  // Bus HREADY is the muxed response fed back.
  assign HREADY = HREADYOUT_M;

  always #5 HCLK = ~HCLK;

  ahb_err_inject_sched #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cfg_enable(cfg_enable), .cfg_addr_lo(cfg_addr_lo), .cfg_addr_hi(cfg_addr_hi),
    .cfg_period(cfg_period), .cfg_budget(cfg_budget),
    .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE), .HTRANS(HTRANS), .HADDR(HADDR),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HREADYOUT_M(HREADYOUT_M), .HRESP_M(HRESP_M), .inject(inject),
    .inject_count(inject_count), .done(done)
  );

  typedef struct {
    logic err;
    int   waits;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_count = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Monitor: measures each data phase and compares it with the queued expectation.
  logic in_dp = 1'b0;
  int   dp_len, dp_resp_hi, dp_inj_hi;
  exp_t e_m;
  always @(negedge HCLK) begin
    if (!mon_en || HRESET) begin
      in_dp = 1'b0;
    end else begin
      if (in_dp) begin
        dp_len++;
        if (HRESP_M === 1'b1) dp_resp_hi++;
        if (inject === 1'b1) dp_inj_hi++;
        if (HREADY === 1'b1) begin
          in_dp = 1'b0;
          if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            int exp_len;
            e_m = sb_q.pop_front();
            exp_len = e_m.err ? e_m.waits + 2 : e_m.waits + 1;
            check("dp_len", dp_len, exp_len);
            check("dp_resp", dp_resp_hi, e_m.err ? exp_len : 0);
            check("dp_inject", dp_inj_hi, e_m.err ? exp_len : 0);
          end
        end
      end
      if (HSEL && HREADY && HTRANS[1]) begin
        in_dp      = 1'b1;
        dp_len     = 0;
        dp_resp_hi = 0;
        dp_inj_hi  = 0;
      end
    end
  end

  task automatic push_exp(input logic err, input int waits);
    exp_t e;
    e.err   = err;
    e.waits = waits;
    sb_q.push_back(e);
    if (err) exp_count++;
  endtask

  task automatic set_cfg(input logic en, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                         input logic [CW-1:0] per, input logic [CW-1:0] bud);
    cfg_enable  = en;
    cfg_addr_lo = lo;
    cfg_addr_hi = hi;
    cfg_period  = per;
    cfg_budget  = bud;
  endtask

  task automatic bus_idle();
    HSEL      = 1'b0;
    HTRANS    = 2'b00;
    HADDR     = '0;
    HWRITE    = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    bus_idle();
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    sb_q.delete();
    exp_count = 0;
    mon_en = 1'b1;
  endtask

  // Data phase: slave holds HREADYOUT low for 'waits' cycles, then waits for
  // the bus HREADY to go high. Returns at #1 after the edge ending the phase.
  task automatic wait_dp(input int waits);
    int   cyc = 0;
    logic fin = 1'b0;
    while (!fin) begin
      HREADYOUT = (cyc < waits) ? 1'b0 : 1'b1;
      @(negedge HCLK);
      fin = HREADY;
      @(posedge HCLK);
      #1;
      cyc++;
      if (!fin && cyc > 40) begin
        check("dp_timeout", 32'd0, 32'd1);
        fin = 1'b1;
      end
    end
  endtask

  task automatic xfer(input logic [AW-1:0] addr, input logic [1:0] trans, input int waits,
                      input logic err);
    HSEL      = 1'b1;
    HTRANS    = trans;
    HADDR     = addr;
    HWRITE    = addr[2];
    HREADYOUT = 1'b1;
    push_exp(err, waits);
    @(posedge HCLK);
    #1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    wait_dp(waits);
  endtask

  // Second address phase held on the bus until accepted during the first data phase.
  task automatic b2b(input logic [AW-1:0] a1, input logic e1, input logic [AW-1:0] a2,
                     input logic e2);
    logic fin;
    int   cyc;
    HSEL      = 1'b1;
    HTRANS    = 2'b10;
    HADDR     = a1;
    HREADYOUT = 1'b1;
    push_exp(e1, 0);
    @(posedge HCLK);
    #1;
    HADDR = a2;
    push_exp(e2, 0);
    fin = 1'b0;
    cyc = 0;
    while (!fin) begin
      @(negedge HCLK);
      fin = HREADY;
      @(posedge HCLK);
      #1;
      cyc++;
      if (!fin && cyc > 40) begin
        check("b2b_timeout", 32'd0, 32'd1);
        fin = 1'b1;
      end
    end
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    wait_dp(0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    HRESET = 1'b1;
    bus_idle();
    set_cfg(1'b1, 32'h1000, 32'h2000, 16'd1, 16'd1);
    #3;
    check("rst_hreadyout_m", HREADYOUT_M, 1'b1);
    check("rst_hresp_m", HRESP_M, 1'b0);
    check("rst_inject", inject, 1'b0);
    check("rst_count", inject_count, 16'd0);
    check("rst_done", done, 1'b0);
    HREADYOUT = 1'b0;
    HRESP     = 1'b1;
    #1;
    check("rst_pass_hro", HREADYOUT_M, 1'b0);
    check("rst_pass_hresp", HRESP_M, 1'b1);

    // Window, period 1, unlimited budget, including window edges.
    set_cfg(1'b1, 32'h1000, 32'h2000, 16'd1, 16'd0);
    do_reset();
    xfer(32'h1800, 2'b10, 0, 1'b1);
    check("win_count1", inject_count, exp_count);
    xfer(32'h2000, 2'b10, 0, 1'b0);
    xfer(32'h0FFF, 2'b10, 0, 1'b0);
    xfer(32'h1000, 2'b10, 0, 1'b1);
    xfer(32'h1FFF, 2'b10, 0, 1'b1);
    cfg_addr_hi = 32'h1000;
    xfer(32'h1000, 2'b10, 0, 1'b0);
    check("win_count", inject_count, exp_count);
    check("win_done_unlim", done, 1'b0);

    // Period 3: every third qualifying SEQ transfer.
    set_cfg(1'b1, 32'h1000, 32'h2000, 16'd3, 16'd0);
    do_reset();
    for (int i = 0; i < 6; i++) xfer(32'h1100 + 32'(4 * i), 2'b11, 0, (i % 3) == 2);
    check("per3_count", inject_count, 16'd2);

    // Period 0 behaves as 1.
    cfg_period = 16'd0;
    do_reset();
    xfer(32'h1200, 2'b10, 0, 1'b1);
    xfer(32'h1204, 2'b10, 0, 1'b1);
    check("per0_count", inject_count, 16'd2);

    // Budget 2: third and fourth pass through.
    set_cfg(1'b1, 32'h1000, 32'h2000, 16'd1, 16'd2);
    do_reset();
    xfer(32'h1300, 2'b10, 0, 1'b1);
    check("bud_done_after1", done, 1'b0);
    xfer(32'h1304, 2'b10, 0, 1'b1);
    check("bud_done_after2", done, 1'b1);
    xfer(32'h1308, 2'b10, 0, 1'b0);
    xfer(32'h130C, 2'b10, 0, 1'b0);
    check("bud_count", inject_count, 16'd2);
    check("bud_done_end", done, 1'b1);

    // Wait states: errored (ERR1 4 cycles + ERR2) and passed through.
    set_cfg(1'b1, 32'h1000, 32'h2000, 16'd1, 16'd0);
    do_reset();
    xfer(32'h1400, 2'b10, 3, 1'b1);
    xfer(32'h3000, 2'b10, 2, 1'b0);
    check("wait_count", inject_count, exp_count);

    // Back to back: second phase accepted in ERR2.
    do_reset();
    b2b(32'h1500, 1'b1, 32'h1504, 1'b1);
    check("b2b_count", inject_count, 16'd2);
    b2b(32'h1508, 1'b1, 32'h5000, 1'b0);
    check("b2b_count2", inject_count, 16'd3);

    // Enable dropped during ERR1 does not abort the sequence.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h1600; HREADYOUT = 1'b1;
    push_exp(1'b1, 1);
    @(posedge HCLK);
    #1;
    cfg_enable = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00;
    wait_dp(1);
    check("endrop_count", inject_count, exp_count);

    // Disabled: no errors on qualifying transfers.
    for (int i = 0; i < 10; i++) xfer(32'h1700 + 32'(4 * i), 2'b10, 0, 1'b0);
    check("dis_count", inject_count, exp_count);

    // Reset pulse in ERR1.
    cfg_enable = 1'b1;
    mon_en = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h1800; HREADYOUT = 1'b1;
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; HTRANS = 2'b00; HREADYOUT = 1'b0;
    @(negedge HCLK);
    check("pre_rst_inject", inject, 1'b1);
    check("pre_rst_hresp_m", HRESP_M, 1'b1);
    #1;
    HREADYOUT = 1'b1;
    HRESET = 1'b1;
    #1;
    check("mid_rst_hro", HREADYOUT_M, 1'b1);
    check("mid_rst_hresp", HRESP_M, 1'b0);
    check("mid_rst_inject", inject, 1'b0);
    check("mid_rst_count", inject_count, 16'd0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    HRESP = 1'b1;
    @(negedge HCLK);
    check("post_rst_hresp", HRESP_M, 1'b1);
    check("post_rst_inject", inject, 1'b0);
    check("post_rst_done", done, 1'b0);
    HRESP = 1'b0;
    @(posedge HCLK);
    #1;

    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
